// File: rtl/sync_preq_pkg.sv
// Shared defaults and sizing helpers for the sync_preq pulse-to-toggle request channel.
package sync_preq_pkg;

  localparam int unsigned DEF_SYNC      = 2;
  localparam int unsigned DEF_PEND_BITS = 4;

  // Bits needed to count from 0 up to and including n.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_preq_sync_ff.sv
// Multi-stage flip-flop synchronizer for a single asynchronous level; reusable by any CDC block.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sync_preq.sv
// Source side of a toggle request/acknowledge link: queues single-cycle events and
// emits one out_req toggle per event, waiting for each toggle to be echoed back.
module sync_preq
  import sync_preq_pkg::*;
#(
  parameter int unsigned SYNC      = DEF_SYNC,
  parameter int unsigned PEND_BITS = DEF_PEND_BITS
) (
  input  logic                 in_clock,
  input  logic                 in_reset_n,
  input  logic                 in_pulse,
  input  logic                 ack_toggle,
  input  logic                 clear_overflow,
  output logic                 out_req,
  output logic                 busy,
  output logic [PEND_BITS-1:0] pending,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    ST_RESYNC   = 2'd0,
    ST_IDLE     = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_e;

  localparam int unsigned          SETTLE_W    = cnt_width(SYNC);
  localparam logic [SETTLE_W-1:0]  SETTLE_DONE = SETTLE_W'(SYNC);
  localparam logic [PEND_BITS-1:0] PEND_MAX    = '1;

  state_e               state_q;
  logic                 req_q;
  logic                 busy_q;
  logic                 ovf_q;
  logic [PEND_BITS-1:0] pend_q;
  logic [SETTLE_W-1:0]  settle_q;

  logic ack_sync;
  logic done;
  logic settled;
  logic has_pend;
  logic pend_full;
  logic queue_evt;
  logic drop_evt;

  sync_ff #(
    .STAGES(SYNC)
  ) u_ack_sync (
    .clk_i (in_clock),
    .rst_ni(in_reset_n),
    .d_i   (ack_toggle),
    .q_o   (ack_sync)
  );

  assign done      = (ack_sync == req_q);
  assign has_pend  = (pend_q != '0);
  assign pend_full = (pend_q == PEND_MAX);

  // The chain resets to 0 and cannot reflect a held-high ack until it has been flushed,
  // so RESYNC ignores done until SYNC edges have passed since reset release.
  assign settled = (settle_q == SETTLE_DONE);

  // Events arriving while no toggle can be issued go into the queue.
  assign queue_evt = in_pulse &&
                     ((state_q == ST_RESYNC) || ((state_q == ST_WAIT_ACK) && !done));
  assign drop_evt  = queue_evt && pend_full;

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q  <= ST_RESYNC;
      req_q    <= 1'b0;
      busy_q   <= 1'b1;
      ovf_q    <= 1'b0;
      pend_q   <= '0;
      settle_q <= '0;
    end else begin
      if (!settled) begin
        settle_q <= settle_q + 1'b1;
      end

      if (drop_evt) begin
        ovf_q <= 1'b1;
      end else if (clear_overflow) begin
        ovf_q <= 1'b0;
      end

      if (queue_evt && !pend_full) begin
        pend_q <= pend_q + 1'b1;
      end

      case (state_q)
        ST_RESYNC: begin
          if (settled && done) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end

        ST_IDLE: begin
          if (has_pend || in_pulse) begin
            req_q   <= ~req_q;
            state_q <= ST_WAIT_ACK;
            busy_q  <= 1'b1;
            // A new pulse replaces the dequeued event, leaving the count unchanged.
            if (has_pend && !in_pulse) begin
              pend_q <= pend_q - 1'b1;
            end
          end
        end

        ST_WAIT_ACK: begin
          if (done) begin
            if (has_pend || in_pulse) begin
              req_q <= ~req_q;
              if (has_pend && !in_pulse) begin
                pend_q <= pend_q - 1'b1;
              end
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= ST_RESYNC;
          busy_q  <= 1'b1;
        end
      endcase
    end
  end

  assign out_req  = req_q;
  assign busy     = busy_q;
  assign pending  = pend_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_sync_preq.sv
// Directed self-checking bench for sync_preq; the acknowledge side is emulated by flipping ack_toggle.
module tb_sync_preq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pulse = 1'b0;
  logic       ack = 1'b0;
  logic       clr = 1'b0;
  logic       req, busy, ovf;
  logic [3:0] pend;
  logic       req2, busy2, ovf2;
  logic [1:0] pend2;

  int   tests_run = 0;
  int   tests_failed = 0;
  logic exp_req = 1'b0;
  logic cnt_en = 1'b0;
  int   tog_cnt = 0;

  always #5 clk = ~clk;

  sync_preq u_dut (
    .in_clock      (clk),
    .in_reset_n    (rst_n),
    .in_pulse      (pulse),
    .ack_toggle    (ack),
    .clear_overflow(clr),
    .out_req       (req),
    .busy          (busy),
    .pending       (pend),
    .overflow      (ovf)
  );

  sync_preq #(
    .SYNC     (2),
    .PEND_BITS(2)
  ) u_dut2 (
    .in_clock      (clk),
    .in_reset_n    (rst_n),
    .in_pulse      (pulse),
    .ack_toggle    (ack),
    .clear_overflow(clr),
    .out_req       (req2),
    .busy          (busy2),
    .pending       (pend2),
    .overflow      (ovf2)
  );

  always @(req) if (cnt_en) tog_cnt++;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pulse = 1'b0; ack = 1'b0; clr = 1'b0;
    cyc(2);
    tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %0b want 0", req); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL reset_busy: got %0b want 1", busy); end
    tests_run++; if (pend !== 4'd0) begin tests_failed++; $display("FAIL reset_pend: got %0d want 0", pend); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf: got %0b want 0", ovf); end
    tests_run++; if (busy2 !== 1'b1) begin tests_failed++; $display("FAIL reset_busy2: got %0b want 1", busy2); end
    rst_n = 1'b1;
    cyc(2);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL resync_hold_busy: got %0b want 1", busy); end
    cyc(1);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL resync_exit_busy: got %0b want 0", busy); end
    exp_req = 1'b0;
    $display("[TB] test_reset done");
  endtask

  task automatic test_single_pulse();
    pulse = 1'b1;
    cyc(1);
    pulse = 1'b0;
    exp_req = 1'b1;
    tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL single_req: got %0b want %0b", req, exp_req); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy: got %0b want 1", busy); end
    tests_run++; if (pend !== 4'd0) begin tests_failed++; $display("FAIL single_pend: got %0d want 0", pend); end
    ack = 1'b1;
    cyc(2);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL single_wait_busy: got %0b want 1", busy); end
    cyc(1);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_idle_busy: got %0b want 0", busy); end
    tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL single_idle_req: got %0b want %0b", req, exp_req); end
    $display("[TB] test_single_pulse done");
  endtask

  task automatic test_back_to_back();
    tog_cnt = 0;
    cnt_en = 1'b1;
    pulse = 1'b1;
    cyc(1);
    exp_req = ~exp_req;
    tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL b2b_first_req: got %0b want %0b", req, exp_req); end
    for (int i = 1; i <= 5; i++) begin
      cyc(1);
      tests_run++; if (pend !== 4'(i)) begin tests_failed++; $display("FAIL b2b_fill_pend: got %0d want %0d", pend, i); end
    end
    pulse = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      ack = exp_req;
      cyc(2);
      tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL b2b_early_req: got %0b want %0b", req, exp_req); end
      cyc(1);
      exp_req = ~exp_req;
      tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL b2b_drain_req: got %0b want %0b", req, exp_req); end
      tests_run++; if (pend !== 4'(5 - k)) begin tests_failed++; $display("FAIL b2b_drain_pend: got %0d want %0d", pend, 5 - k); end
    end
    ack = exp_req;
    cyc(3);
    cnt_en = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle_busy: got %0b want 0", busy); end
    tests_run++; if (tog_cnt !== 6) begin tests_failed++; $display("FAIL b2b_toggles: got %0d want 6", tog_cnt); end
    $display("[TB] test_back_to_back done");
  endtask

  task automatic test_coincident();
    pulse = 1'b1;
    cyc(1);
    exp_req = ~exp_req;
    tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL coin_first_req: got %0b want %0b", req, exp_req); end
    cyc(2);
    pulse = 1'b0;
    tests_run++; if (pend !== 4'd2) begin tests_failed++; $display("FAIL coin_fill_pend: got %0d want 2", pend); end
    ack = exp_req;
    cyc(2);
    pulse = 1'b1;
    cyc(1);
    pulse = 1'b0;
    exp_req = ~exp_req;
    tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL coin_req: got %0b want %0b", req, exp_req); end
    tests_run++; if (pend !== 4'd2) begin tests_failed++; $display("FAIL coin_pend: got %0d want 2", pend); end
    for (int k = 1; k <= 2; k++) begin
      ack = exp_req;
      cyc(3);
      exp_req = ~exp_req;
      tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL coin_drain_req: got %0b want %0b", req, exp_req); end
      tests_run++; if (pend !== 4'(2 - k)) begin tests_failed++; $display("FAIL coin_drain_pend: got %0d want %0d", pend, 2 - k); end
    end
    ack = exp_req;
    cyc(3);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL coin_idle_busy: got %0b want 0", busy); end
    $display("[TB] test_coincident done");
  endtask

  task automatic test_reset_ack_high();
    // ack is 1 here and stays 1 through reset release.
    rst_n = 1'b0;
    cyc(1);
    tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL ackhi_reset_req: got %0b want 0", req); end
    rst_n = 1'b1;
    cyc(5);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ackhi_resync_busy: got %0b want 1", busy); end
    tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL ackhi_resync_req: got %0b want 0", req); end
    pulse = 1'b1;
    cyc(2);
    pulse = 1'b0;
    tests_run++; if (pend !== 4'd2) begin tests_failed++; $display("FAIL ackhi_pend: got %0d want 2", pend); end
    tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL ackhi_hold_req: got %0b want 0", req); end
    ack = 1'b0;
    cyc(3);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ackhi_idle_busy: got %0b want 0", busy); end
    tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL ackhi_idle_req: got %0b want 0", req); end
    cyc(1);
    exp_req = 1'b1;
    tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL ackhi_tog1_req: got %0b want %0b", req, exp_req); end
    tests_run++; if (pend !== 4'd1) begin tests_failed++; $display("FAIL ackhi_tog1_pend: got %0d want 1", pend); end
    ack = exp_req;
    cyc(3);
    exp_req = ~exp_req;
    tests_run++; if (req !== exp_req) begin tests_failed++; $display("FAIL ackhi_tog2_req: got %0b want %0b", req, exp_req); end
    tests_run++; if (pend !== 4'd0) begin tests_failed++; $display("FAIL ackhi_tog2_pend: got %0d want 0", pend); end
    ack = exp_req;
    cyc(3);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ackhi_end_busy: got %0b want 0", busy); end
    $display("[TB] test_reset_ack_high done");
  endtask

  task automatic test_reset_mid();
    pulse = 1'b1;
    cyc(4);
    pulse = 1'b0;
    tests_run++; if (req !== 1'b1) begin tests_failed++; $display("FAIL mid_req: got %0b want 1", req); end
    tests_run++; if (pend !== 4'd3) begin tests_failed++; $display("FAIL mid_pend: got %0d want 3", pend); end
    #3;
    rst_n = 1'b0;
    #1;
    tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL mid_async_req: got %0b want 0", req); end
    tests_run++; if (pend !== 4'd0) begin tests_failed++; $display("FAIL mid_async_pend: got %0d want 0", pend); end
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_async_busy: got %0b want 1", busy); end
    tests_run++; if (ovf !== 1'b0) begin tests_failed++; $display("FAIL mid_async_ovf: got %0b want 0", ovf); end
    ack = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_idle_busy: got %0b want 0", busy); end
    tests_run++; if (pend !== 4'd0) begin tests_failed++; $display("FAIL mid_idle_pend: got %0d want 0", pend); end
    cyc(3);
    tests_run++; if (req !== 1'b0) begin tests_failed++; $display("FAIL mid_noretx_req: got %0b want 0", req); end
    $display("[TB] test_reset_mid done");
  endtask

  task automatic test_overflow();
    pulse = 1'b1;
    cyc(1);
    tests_run++; if (req2 !== 1'b1) begin tests_failed++; $display("FAIL ovf_first_req: got %0b want 1", req2); end
    cyc(3);
    tests_run++; if (pend2 !== 2'd3) begin tests_failed++; $display("FAIL ovf_full_pend: got %0d want 3", pend2); end
    tests_run++; if (ovf2 !== 1'b0) begin tests_failed++; $display("FAIL ovf_full_flag: got %0b want 0", ovf2); end
    cyc(1);
    tests_run++; if (pend2 !== 2'd3) begin tests_failed++; $display("FAIL ovf_drop_pend: got %0d want 3", pend2); end
    tests_run++; if (ovf2 !== 1'b1) begin tests_failed++; $display("FAIL ovf_drop_flag: got %0b want 1", ovf2); end
    clr = 1'b1;
    cyc(1);
    tests_run++; if (ovf2 !== 1'b1) begin tests_failed++; $display("FAIL ovf_setwins_flag: got %0b want 1", ovf2); end
    tests_run++; if (pend2 !== 2'd3) begin tests_failed++; $display("FAIL ovf_setwins_pend: got %0d want 3", pend2); end
    pulse = 1'b0;
    cyc(1);
    clr = 1'b0;
    tests_run++; if (ovf2 !== 1'b0) begin tests_failed++; $display("FAIL ovf_clear_flag: got %0b want 0", ovf2); end
    tests_run++; if (pend !== 4'd5) begin tests_failed++; $display("FAIL ovf_wide_pend: got %0d want 5", pend); end
    $display("[TB] test_overflow done");
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_back_to_back();
    test_coincident();
    test_reset_ack_high();
    test_reset_mid();
    test_overflow();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sync_preq.md
SYNC_PREQ -- requirements
Module: sync_preq

Interface
REQ-001 Parameter SYNC, default 2: number of synchronizer stages on ack_toggle (legal 2-3).
REQ-002 Parameter PEND_BITS, default 4: width of the pending-event counter (legal 2-8).
REQ-003 in_clock  input  1: the single clock; all logic SHALL be clocked on its rising edge.
REQ-004 in_reset_n  input  1: asynchronous, active-low reset.
REQ-005 in_pulse  input  1: single-cycle event request; one event per high cycle.
REQ-006 ack_toggle  input  1: acknowledge level from the destination domain, asynchronous to in_clock.
REQ-007 clear_overflow  input  1: synchronous clear of overflow.
REQ-008 out_req  output  1: request toggle level to the destination synchronizer; driven directly by a flip-flop with no logic after it.
REQ-009 busy  output  1: high in any state other than IDLE.
REQ-010 pending  output  PEND_BITS: number of queued events not yet signalled on out_req.
REQ-011 overflow  output  1: sticky flag; high after at least one event has been dropped.

Function
REQ-012 ack_toggle SHALL pass through a SYNC-stage ASYNC_REG chain; ack_sync is the last stage. done = (ack_sync == out_req).
REQ-013 The FSM SHALL have three states: RESYNC, IDLE, WAIT_ACK.
REQ-014 RESYNC: if done, go to IDLE; otherwise remain in RESYNC. No out_req toggle in this state; in_pulse increments pending.
REQ-015 IDLE with pending>0: toggle out_req, decrement pending by 1, go to WAIT_ACK. If in_pulse is also high, pending is unchanged.
REQ-016 IDLE with pending==0 and in_pulse: toggle out_req on the next edge (latency 1 cycle), go to WAIT_ACK; pending stays 0.
REQ-017 WAIT_ACK with done low: in_pulse increments pending; out_req holds.
REQ-018 WAIT_ACK with done high and pending>0: toggle out_req, stay in WAIT_ACK, pending-1 (+1 if in_pulse is high, i.e. net unchanged).
REQ-019 WAIT_ACK with done high, pending==0, in_pulse high: toggle out_req, stay in WAIT_ACK.
REQ-020 WAIT_ACK with done high, pending==0, in_pulse low: go to IDLE.
REQ-021 An increment at pending == 2^PEND_BITS-1 SHALL drop the event, hold pending, and set overflow.
REQ-022 clear_overflow SHALL clear overflow on the next edge; if a drop occurs in the same cycle, the set wins.
REQ-023 out_req SHALL toggle at most once per done event, so every toggle corresponds to exactly one accepted event.
REQ-024 Round-trip time with a destination sync_pgen echoing out_signal as ack_toggle SHALL be bounded by 1 + SYNC(dest) + 1 + SYNC cycles of the respective clocks.

Reset
REQ-025 Asserting in_reset_n low SHALL asynchronously clear out_req, the synchronizer chain, pending and overflow, set busy to 1, and force the state to RESYNC.
REQ-026 On release, the FSM SHALL leave RESYNC only once ack_sync equals out_req. A destination still holding ack_toggle=1 therefore blocks transmission; no spurious toggle may be emitted.
REQ-027 Reset mid-handshake SHALL discard all queued events; no retransmission.

Structure
REQ-028 State encodings SHALL be local constants. No shared package is required; SYNC defaults stay module parameters.
REQ-029 The ack synchronizer SHALL be one sub-module, sync_ff (SYNC-stage, ASYNC_REG, async active-low reset). It is reusable by other CDC blocks.

Verification
REQ-030 Reset, ack_toggle=0, single in_pulse in IDLE -> out_req toggles 0->1 one cycle later. Echo ack_toggle=1 -> IDLE after SYNC+1 cycles, busy=0.
REQ-031 Five back-to-back in_pulse in WAIT_ACK with ack delayed -> pending counts 1..5. Each echoed ack produces exactly one further toggle until pending=0. Total of 6 toggles.
REQ-032 PEND_BITS=2, 5 pulses while ack is stalled -> pending saturates at 3 and overflow=1. clear_overflow together with a sixth pulse -> overflow stays 1. clear_overflow alone -> overflow=0.
REQ-033 in_pulse coincident with done and pending=2 -> toggle issued and pending remains 2.
REQ-034 ack_toggle held at 1 through reset release -> state stays RESYNC, out_req stays 0, two pulses give pending=2. Dropping ack_toggle to 0 -> IDLE, then two toggles as the ack is echoed.
REQ-035 in_reset_n asserted mid-WAIT_ACK with pending=3 -> all outputs cleared immediately, asynchronously, without a clock edge.
